glitc_conf_sequencer: RTL

GLITC_CONF_SEQUENCER -- requirements
Module: glitc_conf_sequencer

---
 rtl/glitc_conf_pkg.sv | 27 ++
 rtl/glitc_conf_chan.sv | 126 ++++++++++++
 rtl/glitc_conf_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/glitc_conf_pkg.sv
// Shared definitions for the GLITC configuration sequencer: channel state codes,
// register addresses and small elaboration-time helpers.
package glitc_conf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROG      = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_REL  = 3'd4,
    ST_READY     = 3'd5,
    ST_ERROR     = 3'd6
  } chan_state_e;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_STATE  = 2'd2;
  localparam logic [1:0] ADR_EVENT  = 2'd3;

  // Every register field is one byte wide, so the map tops out at eight channels.
  localparam int MAX_CHAN = 8;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/glitc_conf_chan.sv
// One GLITC configuration channel: pin synchronizers, sequencing FSM with a shared
// saturating cycle counter, and the open-drain PROGRAM_B driver.
module glitc_conf_chan
  import glitc_conf_pkg::*;
#(
  parameter int PROG_CYCLES  = 16,
  parameter int INIT_TIMEOUT = 65535,
  parameter int DONE_TIMEOUT = 2**24 - 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        program_req,
  input  logic        release_req,
  input  logic        abort_req,
  input  logic        init_b,
  input  logic        done,
  inout  tri          program_b,
  output chan_state_e state,
  output logic        init_seen,
  output logic        done_seen,
  output logic        error,
  output logic        done_evt,
  output logic        err_evt
);

  localparam int CNT_MAX = max_of(max_of(PROG_CYCLES, INIT_TIMEOUT), DONE_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PROG_LAST = CW'(PROG_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);

  logic [1:0]    init_sync, done_sync;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  chan_state_e   state_d;
  logic          init_seen_d, done_seen_d, error_d, to_error;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      init_sync <= '0;
      done_sync <= '0;
      state     <= ST_IDLE;
      cnt_q     <= '0;
      init_seen <= 1'b0;
      done_seen <= 1'b0;
      error     <= 1'b0;
    end else begin
      init_sync <= {init_sync[0], init_b};
      done_sync <= {done_sync[0], done};
      state     <= state_d;
      cnt_q     <= cnt_d;
      init_seen <= init_seen_d;
      done_seen <= done_seen_d;
      error     <= error_d;
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // PROGRAM overrides everything, ABORT overrides normal sequencing; the counter
  // restarts from zero on every state entry that is timed.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_q;
    init_seen_d = init_seen;
    done_seen_d = done_seen;
    error_d     = error;
    done_evt    = 1'b0;
    err_evt     = 1'b0;
    to_error    = 1'b0;
    if (program_req) begin
      state_d     = ST_PROG;
      cnt_d       = '0;
      init_seen_d = 1'b0;
      done_seen_d = 1'b0;
      error_d     = 1'b0;
    end else if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_PROG: begin
          if (cnt_q == PROG_LAST) begin
            state_d = ST_WAIT_INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_INIT: begin
          if (init_sync[1]) begin
            state_d     = ST_LOAD;
            cnt_d       = '0;
            init_seen_d = 1'b0 | 1'b1;
          end else if (cnt_q == INIT_LAST) begin
            to_error = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_LOAD: begin
          if (done_sync[1]) begin
            state_d     = ST_WAIT_REL;
            done_seen_d = 1'b1;
            done_evt    = 1'b1;
          end else if (cnt_q == DONE_LAST) begin
            to_error = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_REL: if (release_req) state_d = ST_READY;
        ST_READY:    if (!done_sync[1]) to_error = 1'b1;
        ST_IDLE, ST_ERROR: state_d = state;
        default:     state_d = ST_IDLE;
      endcase
    end
    if (to_error) begin
      state_d = ST_ERROR;
      error_d = 1'b1;
      err_evt = 1'b1;
    end
  end

  // Open-drain: only ever pull low; reset returns the state to IDLE and releases the pin.
  assign program_b = (state == ST_PROG) ? 1'b0 : 1'bz;

endmodule

// File: rtl/glitc_conf_sequencer.sv
// Wishbone-controlled configuration sequencer for up to eight GLITC FPGAs, with
// per-channel status, write-1-to-clear events and a registered interrupt.
module glitc_conf_sequencer
  import glitc_conf_pkg::*;
#(
  parameter int NCHAN        = 4,
  parameter int PROG_CYCLES  = 16,
  parameter int INIT_TIMEOUT = 65535,
  parameter int DONE_TIMEOUT = 2**24 - 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [4:0]       adr_i,
  input  logic [31:0]      dat_i,
  input  logic [3:0]       sel_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic             err_o,
  output logic             rty_o,
  output logic [NCHAN-1:0] gready_o,
  output logic [NCHAN-1:0] gprogram_o,
  output logic             irq_o,
  inout  tri   [NCHAN-1:0] PROGRAM_B,
  input  logic [NCHAN-1:0] INIT_B,
  input  logic [NCHAN-1:0] DONE
);

  logic                  ack_q, bus_wr, ctrl_wr, evt_wr;
  logic [MAX_CHAN-1:0]   init_seen, done_seen, ready, error;
  logic [MAX_CHAN-1:0]   done_set, err_set, done_clr, err_clr;
  logic [MAX_CHAN-1:0]   done_evt_q, err_evt_q;
  logic [3*MAX_CHAN-1:0] state_vec;
  logic                  unused_bus;

  // Writes commit only in the first cycle of a strobe, so each access acts once.
  assign bus_wr   = cyc_i & stb_i & we_i & ~ack_q;
  assign ctrl_wr  = bus_wr && (adr_i[1:0] == ADR_CTRL);
  assign evt_wr   = bus_wr && (adr_i[1:0] == ADR_EVENT);
  assign done_clr = evt_wr ? dat_i[7:0]  : '0;
  assign err_clr  = evt_wr ? dat_i[15:8] : '0;

  assign ack_o      = ack_q & cyc_i & stb_i;
  assign err_o      = 1'b0;
  assign rty_o      = 1'b0;
  assign unused_bus = ^{sel_i, adr_i, dat_i};

  for (genvar g = 0; g < MAX_CHAN; g++) begin : g_chan
    if (g < NCHAN) begin : g_used
      chan_state_e st;
      glitc_conf_chan #(
        .PROG_CYCLES (PROG_CYCLES),
        .INIT_TIMEOUT(INIT_TIMEOUT),
        .DONE_TIMEOUT(DONE_TIMEOUT)
      ) u_chan (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .program_req(ctrl_wr & dat_i[g]),
        .release_req(ctrl_wr & dat_i[8+g]),
        .abort_req  (ctrl_wr & dat_i[16+g]),
        .init_b     (INIT_B[g]),
        .done       (DONE[g]),
        .program_b  (PROGRAM_B[g]),
        .state      (st),
        .init_seen  (init_seen[g]),
        .done_seen  (done_seen[g]),
        .error      (error[g]),
        .done_evt   (done_set[g]),
        .err_evt    (err_set[g])
      );
      assign state_vec[3*g +: 3] = st;
      assign ready[g]            = (st == ST_READY);
      assign gready_o[g]         = (st == ST_READY);
      assign gprogram_o[g]       = (st == ST_PROG);
    end else begin : g_absent
      assign state_vec[3*g +: 3] = 3'd0;
      assign init_seen[g]        = 1'b0;
      assign done_seen[g]        = 1'b0;
      assign ready[g]            = 1'b0;
      assign error[g]            = 1'b0;
      assign done_set[g]         = 1'b0;
      assign err_set[g]          = 1'b0;
    end
  end

  // Hardware set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q      <= 1'b0;
      done_evt_q <= '0;
      err_evt_q  <= '0;
      irq_o      <= 1'b0;
    end else begin
      ack_q      <= cyc_i & stb_i & ~ack_q;
      done_evt_q <= done_set | (done_evt_q & ~done_clr);
      err_evt_q  <= err_set | (err_evt_q & ~err_clr);
      irq_o      <= |{done_evt_q, err_evt_q};
    end
  end

  always_comb begin
    dat_o = '0;
    case (adr_i[1:0])
      ADR_STATUS: dat_o = {error, ready, done_seen, init_seen};
      ADR_STATE:  dat_o = {8'd0, state_vec};
      ADR_EVENT:  dat_o = {16'd0, err_evt_q, done_evt_q};
      default:    dat_o = '0;
    endcase
  end

endmodule
